// File: rtl/fullrate.sv
// rtl/fullrate.sv - repacks one-sample-every-other-cycle input into a back-to-back burst in the next frame
// Optional counter discontinuity checker: define FULLRATE_CNT_CHECK_EN.
module fullrate #(
  parameter int DBW = 3,
  parameter int CBW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CBW-1:0] cnt,
  input  logic [DBW-1:0] din,
  output logic [DBW-1:0] dout,
  output logic           dvalid,
  output logic           err
);

  localparam int M = 2 ** (CBW - 1);
  localparam logic [CBW-1:0] CNT_ONE  = CBW'(1);
  localparam logic [CBW-1:0] CNT_LAST = '1;

  logic [DBW-1:0] mem [M];
  logic           started;
  logic           primed;
  logic           restart;
  logic           wr_en;
  logic           rd_en;
  logic [CBW-2:0] wr_addr;
  logic [CBW-2:0] rd_addr;

  assign wr_en   = cnt[0];
  assign wr_addr = cnt[CBW-1:1];
  assign rd_addr = cnt[CBW-2:0];
  assign rd_en   = !cnt[CBW-1] && primed;

  // Slot k is read at cnt=k, before the next frame rewrites it at cnt=2k+1.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

`ifdef FULLRATE_CNT_CHECK_EN
  logic [CBW-1:0] prev_cnt;
  logic [CBW-1:0] exp_cnt;
  logic           armed;

  assign exp_cnt = prev_cnt + CNT_ONE;
  assign restart = armed && (cnt != exp_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt <= '0;
      armed    <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev_cnt <= cnt;
      armed    <= 1'b1;
      err      <= restart;
    end
  end
`else
  assign restart = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      primed  <= 1'b0;
      dout    <= '0;
      dvalid  <= 1'b0;
    end else begin
      dvalid <= rd_en;
      if (rd_en) dout <= mem[rd_addr];
      // A discontinuity discards the partially collected frame.
      if (restart) begin
        started <= 1'b0;
        primed  <= 1'b0;
      end else if (wr_en) begin
        if (cnt == CNT_ONE) started <= 1'b1;
        if (cnt == CNT_LAST && started) primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fullrate.sv
// tb/tb_fullrate.sv - randomized bench for fullrate against a history-based reference model
module tb_fullrate;

  localparam int DBW = 8;
  localparam int CBW = 4;
  localparam int N   = 16;
  localparam int M   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [CBW-1:0] cnt = '0;
  logic [DBW-1:0] din = '0;
  logic [DBW-1:0] dout;
  logic           dvalid;
  logic           err;

  int errors = 0;
  int checks = 0;

  fullrate #(.DBW(DBW), .CBW(CBW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cnt(cnt),
    .din(din),
    .dout(dout),
    .dvalid(dvalid),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sample k of a frame is the din seen N-k-1 cycles before the read cycle,
  // emitted only once a complete frame starting at cnt=1 has been seen in the current epoch.
  int hc[$];
  int hd[$];
  int ep = 0;
  logic [DBW-1:0] m_dout = '0;
  logic           m_dvalid = 1'b0;
  logic           m_err = 1'b0;

  always @(posedge clk) begin : model
    int t;
    int c;
    bit prim;
    if (!rst_n) begin
      hc.delete();
      hd.delete();
      ep = 0;
      m_dout = '0;
      m_dvalid = 1'b0;
      m_err = 1'b0;
    end else begin
      c = int'(cnt);
      hc.push_back(c);
      hd.push_back(int'(din));
      t = hc.size() - 1;
      m_err = 1'b0;
`ifdef FULLRATE_CNT_CHECK_EN
      if (t > 0 && c != (hc[t-1] + 1) % N) m_err = 1'b1;
`endif
      prim = 1'b0;
      for (int s = ep; s < t; s++) begin
        if (hc[s] == 1) begin
          prim = (s + N - 2 < t);
          break;
        end
      end
      m_dvalid = prim && (c < M);
      if (m_dvalid) m_dout = DBW'(hd[t - N + c + 1]);
      if (m_err) ep = t + 1;
    end
    #1;
    chk("dvalid", dvalid, m_dvalid);
    chk("dout", dout, m_dout);
    chk("err", err, m_err);
  end

  task automatic step(input int c, input int d);
    cnt = CBW'(c);
    din = DBW'(d);
    @(posedge clk);
    #3;
  endtask

  function automatic int odd_data(input int base, input int c);
    return (c % 2 == 1) ? base + c / 2 : int'($urandom_range(0, 255));
  endfunction

  // pin >= 0: literal burst values expected; pin == -2: no dvalid expected in the first half.
  task automatic frame(input int base, input bit ff, input int pin);
    int d;
    for (int c = 0; c < N; c++) begin
      if (c % 2 == 1) d = base + c / 2;
      else d = ff ? 'hFF : int'($urandom_range(0, 255));
      step(c, d);
      if (pin >= 0 && c < M) begin
        chk("pin_dout", dout, 32'(pin + c));
        chk("pin_dvalid", dvalid, 1);
      end
      if (pin >= 0 && c == M) chk("pin_tail_dvalid", dvalid, 0);
      if (pin == -2 && c < M) chk("idle_dvalid", dvalid, 0);
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    step(14, 0);
    step(15, 0);
    chk("reset_dvalid", dvalid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;

    frame('h10, 1'b0, -2);
    frame('h20, 1'b1, 'h10);
    frame('h40, 1'b1, 'h20);
    frame('h60, 1'b0, 'h40);

    for (int c = 0; c < 4; c++) step(c, odd_data('h70, c));
    chk("pre_rst_dvalid", dvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dvalid", dvalid, 0);
    chk("async_rst_dout", dout, 0);
    for (int c = 4; c < N; c++) step(c, odd_data('h70, c));

    for (int c = 0; c < 5; c++) step(c, odd_data('h11, c));
    rst_n = 1'b1;
    for (int c = 5; c < N; c++) step(c, odd_data('h11, c));
    frame('h30, 1'b0, -2);
    frame('h50, 1'b0, 'h30);

    for (int i = 0; i < 8; i++) frame(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);

    for (int i = 0; i < 3; i++) begin
      rst_n = 1'b0;
      r = int'($urandom_range(0, N - 1));
      for (int c = 0; c < r; c++) step(c, int'($urandom_range(0, 255)));
      rst_n = 1'b1;
      for (int c = r; c < N; c++) step(c, int'($urandom_range(0, 255)));
      for (int f = 0; f < 2; f++) frame(int'($urandom_range(0, 255)), 1'b0, -1);
    end

`ifdef FULLRATE_CNT_CHECK_EN
    frame('h60, 1'b0, -1);
    for (int c = 0; c < 7; c++) step(c, odd_data('h70, c));
    step(9, odd_data('h70, 9));
    chk("jump_err", err, 1);
    step(10, odd_data('h70, 10));
    chk("jump_err_clear", err, 0);
    for (int c = 11; c < N; c++) step(c, odd_data('h70, c));
    frame('h80, 1'b0, -2);
    frame('h90, 1'b0, 'h80);
`endif

    step(0, 0);
    step(1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fullrate.md
# fullrate

Inverse of the FFT half-rate spreader. It accepts one sample every other cycle across a full counter frame of 2^CBW cycles. It re-emits those samples back-to-back, one per cycle, during the first half of the following frame. It sits on the FFT datapath after the half-rate stage, driven by the same free-running frame counter.

## Interface
Parameters:
- DBW, 3, sample width in bits.
- CBW, 3, frame counter width; frame length N = 2^CBW, samples per frame M = N/2; CBW >= 2.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cnt  input  CBW  free-running frame counter, increments by 1 per cycle and wraps N-1 -> 0.
- din  input  DBW  input sample; meaningful only when cnt[0]=1.
- dout  output  DBW  packed output sample, registered.
- dvalid  output  1  dout carries a sample this cycle, registered.
- err  output  1  counter discontinuity pulse; tied 0 unless FULLRATE_CNT_CHECK_EN is defined.

## Operation
- Single-port-write / single-port-read buffer `mem` of M entries × DBW. It is not reset.
- Write: when cnt[0]=1, `mem[cnt[CBW-1:1]] <= din`. Slot k is written at cnt = 2k+1.
- Read: when cnt[CBW-1]=0 and `primed`=1, `dout <= mem[cnt[CBW-2:0]]` and `dvalid <= 1`. Slot k is read at cnt = k.
- Otherwise `dvalid <= 0` and dout holds its previous value.
- No read/write hazard: slot k is read at cycle k, and the next frame overwrites it at cycle 2k+1 > k. A single buffer suffices; no ping-pong is needed.
- Priming flags:
  - `started` is set on the write at cnt=1 (slot 0).
  - `primed` is set on the write at cnt=N-1 if `started`=1.
  - Once set, both stay set until reset (or until an err event, see Configuration).
- The first frame after reset therefore produces no dvalid. A frame entered mid-way after reset, without a slot-0 write, is never emitted.
- Even-cycle din values are ignored entirely.
- Reset (any time, including mid-frame): dout=0, dvalid=0, err=0, started=0, primed=0. Buffer contents are irrelevant because priming restarts.

## Timing
- Latency: sample k of frame F (din at cnt=2k+1) appears on dout with dvalid=1 at cnt=k+1 of frame F+1.
  - Sample M-1 (din at cnt=N-1) appears at cnt=M of frame F+1.
- Within a primed frame, dvalid is high for exactly cnt = 1..M (M consecutive cycles) and low for cnt = M+1..N-1 and cnt=0.
- First possible dvalid after reset release: cnt=1 of the frame following the first complete frame (slot 0 through slot M-1 all written).
- Read data is one registered stage; there is no combinational path from din to dout.

## Configuration
- FULLRATE_CNT_CHECK_EN defined:
  - A register holds the previous cnt. When the checker is armed (one cycle after reset release) and cnt != (prev+1) mod N, err pulses high for one cycle on the following cycle.
  - On that event, started and primed clear in the same cycle err is registered. dvalid stays 0 until a new complete frame is collected.
  - An output read already registered is not suppressed.
- FULLRATE_CNT_CHECK_EN undefined: err tied 0, no previous-cnt register. The block trusts cnt; behaviour on a discontinuity is unspecified.

## Test plan
- DBW=8, CBW=4 (N=16, M=8): reset, then two full frames with din=0x10+k at cnt=2k+1 -> frame 2 shows dvalid at cnt 1..8 with dout 0x10..0x17, and dvalid is 0 elsewhere and during frame 1.
- Same setup, even-cycle din driven 0xFF -> output identical to the previous case.
- Back-to-back frames with frame F data 0x20+k and frame F+1 data 0x40+k -> frame F+1 emits 0x20..0x27 uncorrupted, frame F+2 emits 0x40..0x47.
- Reset released at cnt=5 -> no dvalid in the next frame's first half; first dvalid follows the first full frame.
- Assert rst_n=0 at cnt=3 during output -> dvalid and dout drop to 0 asynchronously; no output until a new full frame is collected.
- With FULLRATE_CNT_CHECK_EN: jump cnt 6 -> 9 while primed -> err=1 for one cycle, dvalid 0 in the next frame, normal output resumes one full frame later. Without the macro, err stays 0.
